// File: rtl/photon_capture_pkg.sv
// Shared types and helpers for the photon snapshot capture controller.
package photon_capture_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned PIX_W_DEF  = 12;
  localparam int unsigned DAT_W_DEF  = 20;
  localparam int unsigned DEPTH      = 2 ** ADDR_W_DEF;
  localparam int unsigned WORD_W     = 32;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StCapture = 2'd2,
    StDone    = 2'd3
  } state_t;

  // Pixel ID goes in the MSBs so software can demux words by channel.
  function automatic logic [WORD_W-1:0] pack_word(input logic [PIX_W_DEF-1:0] pix,
                                                  input logic [DAT_W_DEF-1:0] data);
    return {pix, data};
  endfunction

endpackage

// File: rtl/photon_capture_ctrl_filter.sv
// Accept decode for the incoming sample stream plus the one-cycle RAM write stage.
module photon_capture_ctrl_filter
  import photon_capture_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned PIX_W  = PIX_W_DEF,
  parameter int unsigned DAT_W  = DAT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              st_armed_i,
  input  logic              st_capture_i,
  input  logic              st_done_full_i,
  input  logic              arm_i,
  input  logic              trig_i,
  input  logic              filt_en_i,
  input  logic [PIX_W-1:0]  sel_pix_i,
  input  logic              in_valid_i,
  input  logic [PIX_W-1:0]  in_pix_i,
  input  logic [DAT_W-1:0]  in_data_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  output logic              accept_o,
  output logic              drop_o,
  output logic              bram_we_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  output logic [WORD_W-1:0] bram_wr_data_o
);

  logic              match;
  logic              accept;
  logic              we_d, we_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [WORD_W-1:0] data_d, data_q;

  always_comb begin
    match  = in_valid_i && (!filt_en_i || (in_pix_i == sel_pix_i));
    // arm overrides trig and cancels whatever would have been written this cycle.
    accept = match && !arm_i && (st_capture_i || (st_armed_i && trig_i));
    drop_o = match && !arm_i && st_done_full_i;
    accept_o = accept;
    we_d   = accept;
    addr_d = accept ? wr_addr_i : addr_q;
    data_d = accept ? pack_word(in_pix_i, in_data_i) : data_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign bram_we_o      = we_q;
  assign bram_addr_o    = addr_q;
  assign bram_wr_data_o = data_q;

endmodule

// File: rtl/photon_capture_ctrl.sv
// Snapshot capture controller: arm/trigger FSM, word/overflow counters, RAM port A driver.
module photon_capture_ctrl
  import photon_capture_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned PIX_W  = PIX_W_DEF,
  parameter int unsigned DAT_W  = DAT_W_DEF,
  parameter int unsigned OVF_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              trig,
  input  logic              stop,
  input  logic              filt_en,
  input  logic [PIX_W-1:0]  sel_pix,
  input  logic              in_valid,
  input  logic [PIX_W-1:0]  in_pix,
  input  logic [DAT_W-1:0]  in_data,
  output logic              bram_we,
  output logic              bram_en_a,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_written,
  output logic [OVF_W-1:0]  ovf_cnt
);

  localparam logic [ADDR_W:0]  WordOne = 1;
  localparam logic [OVF_W-1:0] OvfOne  = 1;

  state_t            state_d, state_q;
  logic [ADDR_W:0]   words_d, words_q;
  logic [OVF_W-1:0]  ovf_d, ovf_q;
  logic              full_d, full_q;
  logic              busy_d, busy_q;
  logic              done_d, done_q;
  logic              accept;
  logic              drop;

  photon_capture_ctrl_filter #(
    .ADDR_W (ADDR_W),
    .PIX_W  (PIX_W),
    .DAT_W  (DAT_W)
  ) u_filter (
    .clk_i          (clk),
    .rst_i          (rst),
    .st_armed_i     (state_q == StArmed),
    .st_capture_i   (state_q == StCapture),
    .st_done_full_i ((state_q == StDone) && full_q),
    .arm_i          (arm),
    .trig_i         (trig),
    .filt_en_i      (filt_en),
    .sel_pix_i      (sel_pix),
    .in_valid_i     (in_valid),
    .in_pix_i       (in_pix),
    .in_data_i      (in_data),
    .wr_addr_i      (words_q[ADDR_W-1:0]),
    .accept_o       (accept),
    .drop_o         (drop),
    .bram_we_o      (bram_we),
    .bram_addr_o    (bram_addr),
    .bram_wr_data_o (bram_wr_data)
  );

  always_comb begin
    state_d = state_q;
    words_d = words_q;
    ovf_d   = ovf_q;
    full_d  = full_q;
    if (arm) begin
      state_d = StArmed;
      words_d = '0;
      ovf_d   = '0;
      full_d  = 1'b0;
    end else begin
      if (accept) words_d = words_q + WordOne;
      if (drop && (ovf_q != '1)) ovf_d = ovf_q + OvfOne;
      unique case (state_q)
        StIdle:  ;
        StArmed: if (trig) state_d = StCapture;
        StCapture: begin
          // The write that fills the last slot is still issued; DONE lands on that same edge.
          if (accept && (&words_q[ADDR_W-1:0])) begin
            state_d = StDone;
            full_d  = 1'b1;
          end else if (stop) begin
            state_d = StDone;
          end
        end
        StDone:  ;
        default: state_d = StIdle;
      endcase
    end
    busy_d = (state_d == StArmed) || (state_d == StCapture);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      words_q <= '0;
      ovf_q   <= '0;
      full_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      ovf_q   <= ovf_d;
      full_q  <= full_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bram_en_a     = bram_we;
  assign busy          = busy_q;
  assign done          = done_q;
  assign words_written = words_q;
  assign ovf_cnt       = ovf_q;

endmodule

// File: tb/tb_photon_capture_ctrl.sv
// Scenario bench for photon_capture_ctrl with a queue scoreboard of expected RAM writes.
module tb_photon_capture_ctrl;

  localparam int AW = 10;
  localparam int PW = 12;
  localparam int DW = 20;
  localparam int OW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arm = 1'b0, trig = 1'b0, stop = 1'b0;
  logic          filt_en = 1'b0;
  logic [PW-1:0] sel_pix = '0;
  logic          in_valid = 1'b0;
  logic [PW-1:0] in_pix = '0;
  logic [DW-1:0] in_data = '0;
  logic          bram_we, bram_en_a, busy, done;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_wr_data;
  logic [AW:0]   words_written;
  logic [OW-1:0] ovf_cnt;

  int checks = 0;
  int fails  = 0;
  int wr_count = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [AW+31:0] exp_q[$];

  always #5 clk = ~clk;

  photon_capture_ctrl u_dut (
    .clk           (clk),
    .rst           (rst),
    .arm           (arm),
    .trig          (trig),
    .stop          (stop),
    .filt_en       (filt_en),
    .sel_pix       (sel_pix),
    .in_valid      (in_valid),
    .in_pix        (in_pix),
    .in_data       (in_data),
    .bram_we       (bram_we),
    .bram_en_a     (bram_en_a),
    .bram_addr     (bram_addr),
    .bram_wr_data  (bram_wr_data),
    .busy          (busy),
    .done          (done),
    .words_written (words_written),
    .ovf_cnt       (ovf_cnt)
  );

  // Scoreboard: every observed write must match the oldest expected one.
  always @(negedge clk) begin
    if (bram_we === 1'b1) begin
      logic [AW+31:0] e;
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write",
                 bram_addr, bram_wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({bram_addr, bram_wr_data} !== e) begin
          fails++;
          $display("FAIL write_word: got addr=%0d data=%h, required addr=%0d data=%h",
                   bram_addr, bram_wr_data, e[AW+31:32], e[31:0]);
        end
      end
      checks++;
      if (bram_en_a !== 1'b1) begin
        fails++;
        $display("FAIL en_a: got %b, required 1", bram_en_a);
      end
    end
  end

  task automatic drive_cycle(input logic a, input logic t, input logic s, input logic v,
                             input logic [PW-1:0] p, input logic [DW-1:0] d,
                             input logic expect_wr);
    arm = a; trig = t; stop = s; in_valid = v; in_pix = p; in_data = d;
    if (expect_wr) begin
      exp_q.push_back({exp_addr, p, d});
      exp_addr++;
    end
    @(posedge clk); #1;
    arm = 1'b0; trig = 1'b0; stop = 1'b0; in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, '0, '0, 0);
  endtask

  task automatic check_status(input string name, input logic eb, input logic ed,
                              input int ew, input int eo);
    checks++;
    if (busy !== eb) begin
      fails++; $display("FAIL %s busy: got %b, required %b", name, busy, eb);
    end
    checks++;
    if (done !== ed) begin
      fails++; $display("FAIL %s done: got %b, required %b", name, done, ed);
    end
    checks++;
    if (words_written !== (AW+1)'(ew)) begin
      fails++; $display("FAIL %s words_written: got %0d, required %0d", name, words_written, ew);
    end
    checks++;
    if (ovf_cnt !== OW'(eo)) begin
      fails++; $display("FAIL %s ovf_cnt: got %0d, required %0d", name, ovf_cnt, eo);
    end
  endtask

  task automatic check_drained(input string name, input int base, input int ewrites);
    checks++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL %s pending: got %0d unseen writes, required 0", name, exp_q.size());
    end
    checks++;
    if (wr_count - base != ewrites) begin
      fails++; $display("FAIL %s write_count: got %0d, required %0d", name, wr_count - base, ewrites);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({bram_we, bram_en_a, bram_addr, bram_wr_data} !== '0) begin
      fails++;
      $display("FAIL reset_port_a: got we=%b en=%b addr=%0d data=%h, required all 0",
               bram_we, bram_en_a, bram_addr, bram_wr_data);
    end
    check_status("reset", 0, 0, 0, 0);
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_full_capture();
    int base = wr_count;
    filt_en = 1'b0;
    exp_addr = '0;
    drive_cycle(1, 0, 0, 0, '0, '0, 0);
    check_status("full_armed", 1, 0, 0, 0);
    for (int i = 0; i < 1100; i++) begin
      drive_cycle(0, i == 0, 0, 1, PW'(i * 7), DW'(i), i < 1024);
      if (i == 0) begin
        checks++;
        if (bram_we !== 1'b1 || bram_addr !== '0) begin
          fails++;
          $display("FAIL full_first_latency: got we=%b addr=%0d, required we=1 addr=0",
                   bram_we, bram_addr);
        end
      end
    end
    idle(2);
    check_status("full_end", 0, 1, 1024, 76);
    check_drained("full", base, 1024);
  endtask

  task automatic test_filter();
    int base = wr_count;
    logic [PW-1:0] p;
    filt_en = 1'b1;
    sel_pix = 12'h05A;
    exp_addr = '0;
    drive_cycle(1, 0, 0, 0, '0, '0, 0);
    for (int i = 0; i < 50; i++) begin
      p = 12'h058 + PW'(i % 5);
      drive_cycle(0, i == 0, 0, 1, p, DW'(1000 + i), p == 12'h05A);
    end
    idle(2);
    check_status("filter_end", 1, 0, 10, 0);
    check_drained("filter", base, 10);
    drive_cycle(0, 0, 1, 0, '0, '0, 0);
    check_status("filter_stop", 0, 1, 10, 0);
    filt_en = 1'b0;
  endtask

  task automatic test_early_stop();
    int base = wr_count;
    exp_addr = '0;
    drive_cycle(1, 0, 0, 0, '0, '0, 0);
    for (int i = 0; i < 301; i++)
      drive_cycle(0, i == 0, i == 300, 1, PW'(i), DW'(i + 5), 1);
    for (int i = 0; i < 5; i++) drive_cycle(0, 0, 0, 1, PW'(i), DW'(i), 0);
    check_status("stop_end", 0, 1, 301, 0);
    check_drained("stop", base, 301);
    checks++;
    if (bram_addr !== AW'(300) || bram_wr_data !== {PW'(300), DW'(305)}) begin
      fails++;
      $display("FAIL stop_hold: got addr=%0d data=%h, required addr=300 data=%h",
               bram_addr, bram_wr_data, {PW'(300), DW'(305)});
    end
  endtask

  task automatic test_rearm();
    int base = wr_count;
    exp_addr = '0;
    drive_cycle(1, 0, 0, 0, '0, '0, 0);
    for (int i = 0; i < 500; i++) drive_cycle(0, i == 0, 0, 1, PW'(i), DW'(i), 1);
    check_status("rearm_pre", 1, 0, 500, 0);
    drive_cycle(1, 0, 0, 1, 12'hABC, 20'h12345, 0);
    checks++;
    if (bram_we !== 1'b0) begin
      fails++; $display("FAIL rearm_cancel: got we=%b, required 0", bram_we);
    end
    check_status("rearm_post", 1, 0, 0, 0);
    exp_addr = '0;
    for (int i = 0; i < 4; i++) drive_cycle(0, i == 0, 0, 1, PW'(i + 40), DW'(i + 77), 1);
    drive_cycle(0, 0, 1, 0, '0, '0, 0);
    idle(1);
    check_status("rearm_restart", 0, 1, 4, 0);
    check_drained("rearm", base, 504);
  endtask

  task automatic test_arm_trig();
    int base = wr_count;
    exp_addr = '0;
    drive_cycle(1, 0, 0, 0, '0, '0, 0);
    drive_cycle(1, 1, 0, 1, 12'h111, 20'h22222, 0);
    checks++;
    if (bram_we !== 1'b0) begin
      fails++; $display("FAIL armtrig_nowrite: got we=%b, required 0", bram_we);
    end
    check_status("armtrig_held", 1, 0, 0, 0);
    drive_cycle(0, 1, 0, 1, 12'h333, 20'h44444, 1);
    drive_cycle(0, 0, 1, 0, '0, '0, 0);
    idle(1);
    check_status("armtrig_later", 0, 1, 1, 0);
    check_drained("armtrig", base, 1);
  endtask

  task automatic test_reset_mid();
    int base = wr_count;
    exp_addr = '0;
    drive_cycle(1, 0, 0, 0, '0, '0, 0);
    drive_cycle(0, 1, 0, 1, 12'h00F, 20'h0000F, 1);
    drive_cycle(0, 0, 0, 1, 12'h0F0, 20'h000F0, 1);
    checks++;
    if (bram_we !== 1'b1) begin
      fails++; $display("FAIL rstmid_pending: got we=%b, required 1", bram_we);
    end
    rst = 1'b1;
    in_valid = 1'b1; in_pix = 12'hFFF; in_data = 20'hFFFFF;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if ({bram_we, bram_en_a, bram_addr, bram_wr_data} !== '0) begin
      fails++;
      $display("FAIL rstmid_port_a: got we=%b en=%b addr=%0d data=%h, required all 0",
               bram_we, bram_en_a, bram_addr, bram_wr_data);
    end
    check_status("rstmid", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive_cycle(0, 1, 0, 1, PW'(i), DW'(i), 0);
    idle(1);
    check_status("rstmid_trig", 0, 0, 0, 0);
    check_drained("rstmid", base, 2);
  endtask

  initial begin
    test_reset();
    test_full_capture();
    test_filter();
    test_early_stop();
    test_rearm();
    test_arm_trig();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
